// File: rtl/fht_pkg.sv
// rtl/fht_pkg.sv - shared types, defaults and helpers for the FHT butterfly array
package fht_pkg;

    localparam int D_BIT_DEF  = 17;
    localparam int W_BIT_DEF  = 12;
    localparam int W_FRAC_DEF = 10;
    localparam int RND        = 1 << (W_FRAC_DEF - 1);

    typedef enum logic [1:0] {
        PERM_NORM = 2'd0,
        PERM_SWAP = 2'd1,
        PERM_LAST = 2'd2
    } perm_e;

    // Clip a signed value to the range of a signed field of the given width.
    function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = ~hi;
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/fht_but_core.sv
// rtl/fht_but_core.sv - one radix-2 FHT butterfly: twiddle product (S1), round/add/scale/saturate (S2)
module fht_but_core
    import fht_pkg::*;
#(
    parameter int D_BIT  = D_BIT_DEF,
    parameter int W_BIT  = W_BIT_DEF,
    parameter int W_FRAC = W_FRAC_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en1,
    input  logic                     en2,
    input  logic                     st_zero,
    input  logic                     st_last,
    input  logic                     part2,
    input  logic                     scale,
    input  logic signed [D_BIT-1:0]  x0,
    input  logic signed [D_BIT-1:0]  x1,
    input  logic signed [D_BIT-1:0]  x2,
    input  logic signed [W_BIT-1:0]  cos_w,
    input  logic signed [W_BIT-1:0]  sin_w,
    output logic signed [D_BIT-1:0]  s,
    output logic signed [D_BIT-1:0]  d,
    output logic                     ovf,
    output logic                     st_last_q,
    output logic                     part2_q
);

    localparam int PW      = D_BIT + W_BIT + 1;
    localparam int EW      = D_BIT + 2;
    localparam int RND_VAL = (W_FRAC == W_FRAC_DEF) ? RND : (1 << (W_FRAC - 1));
    localparam logic signed [PW-1:0] RND_P = PW'(RND_VAL);
    localparam logic signed [EW-1:0] ONE_E = EW'(1);

    logic signed [PW-1:0] x1e, x2e, ce, se, p_next, p_q, pr;
    logic signed [D_BIT-1:0] x0_q;
    logic scale_q, last_q1, part2_q1;

    logic signed [EW-1:0] t, x0e, s_w, d_w, s_sc, d_sc;
    logic signed [31:0] s_full, d_full;

    assign x1e = PW'(x1);
    assign x2e = PW'(x2);
    assign ce  = PW'(cos_w);
    assign se  = PW'(sin_w);

    always_comb begin
        p_next = x1e * ce + x2e * se;
        if (st_zero)
            p_next = x1e <<< W_FRAC;
    end

    // Stage 2 arithmetic runs at D_BIT+2 bits so sum/diff and the scale rounding never wrap.
    assign pr     = p_q + RND_P;
    assign t      = EW'(pr >>> W_FRAC);
    assign x0e    = EW'(x0_q);
    assign s_w    = x0e + t;
    assign d_w    = x0e - t;
    assign s_sc   = scale_q ? ((s_w + ONE_E) >>> 1) : s_w;
    assign d_sc   = scale_q ? ((d_w + ONE_E) >>> 1) : d_w;
    assign s_full = sat(32'(s_sc), D_BIT);
    assign d_full = sat(32'(d_sc), D_BIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_q       <= '0;
            x0_q      <= '0;
            scale_q   <= 1'b0;
            last_q1   <= 1'b0;
            part2_q1  <= 1'b0;
            s         <= '0;
            d         <= '0;
            ovf       <= 1'b0;
            st_last_q <= 1'b0;
            part2_q   <= 1'b0;
        end else begin
            if (en1) begin
                p_q      <= p_next;
                x0_q     <= x0;
                scale_q  <= scale;
                last_q1  <= st_last;
                part2_q1 <= part2;
            end
            if (en2) begin
                s         <= s_full[D_BIT-1:0];
                d         <= d_full[D_BIT-1:0];
                ovf       <= (s_full != 32'(s_sc)) || (d_full != 32'(d_sc));
                st_last_q <= last_q1;
                part2_q   <= part2_q1;
            end
        end
    end

endmodule

// File: rtl/fht_but_array.sv
// rtl/fht_but_array.sv - pipelined array of FHT butterflies with pairwise output permutation
module fht_but_array
    import fht_pkg::*;
#(
    parameter int D_BIT  = D_BIT_DEF,
    parameter int W_BIT  = W_BIT_DEF,
    parameter int W_FRAC = W_FRAC_DEF,
    parameter int N_BUT  = 2
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iCLR,
    input  logic                       iVALID,
    input  logic                       iST_ZERO,
    input  logic                       iST_LAST,
    input  logic                       i2ND_PART,
    input  logic                       iSCALE,
    input  logic [N_BUT*D_BIT-1:0]     iX0,
    input  logic [N_BUT*D_BIT-1:0]     iX1,
    input  logic [N_BUT*D_BIT-1:0]     iX2,
    input  logic [N_BUT*W_BIT-1:0]     iCOS,
    input  logic [N_BUT*W_BIT-1:0]     iSIN,
    output logic [2*N_BUT*D_BIT-1:0]   oY,
    output logic                       oVALID,
    output logic                       oOVF
);

    logic v1, v2, en1, en2, en3;
    logic [D_BIT-1:0] s_a [N_BUT];
    logic [D_BIT-1:0] d_a [N_BUT];
    logic [N_BUT-1:0] ovf_v, last_v, part2_v;
    logic [2*N_BUT*D_BIT-1:0] y_perm;

    // A flush drops the beat presented with it and everything in flight.
    assign en1 = iVALID & ~iCLR;
    assign en2 = v1 & ~iCLR;
    assign en3 = v2 & ~iCLR;

    for (genvar b = 0; b < N_BUT; b++) begin : g_but
        fht_but_core #(
            .D_BIT (D_BIT),
            .W_BIT (W_BIT),
            .W_FRAC(W_FRAC)
        ) u_core (
            .clk      (iCLK),
            .resetn   (iRESET),
            .en1      (en1),
            .en2      (en2),
            .st_zero  (iST_ZERO),
            .st_last  (iST_LAST),
            .part2    (i2ND_PART),
            .scale    (iSCALE),
            .x0       (iX0[b*D_BIT +: D_BIT]),
            .x1       (iX1[b*D_BIT +: D_BIT]),
            .x2       (iX2[b*D_BIT +: D_BIT]),
            .cos_w    (iCOS[b*W_BIT +: W_BIT]),
            .sin_w    (iSIN[b*W_BIT +: W_BIT]),
            .s        (s_a[b]),
            .d        (d_a[b]),
            .ovf      (ovf_v[b]),
            .st_last_q(last_v[b]),
            .part2_q  (part2_v[b])
        );
    end

    for (genvar k = 0; k < N_BUT / 2; k++) begin : g_pair
        perm_e pm;
        logic [4*D_BIT-1:0] q;
        always_comb begin
            if (last_v[2*k] | last_v[2*k+1])
                pm = PERM_LAST;
            else if (part2_v[2*k] | part2_v[2*k+1])
                pm = PERM_SWAP;
            else
                pm = PERM_NORM;
            // Concatenations list slots highest first: {slot3, slot2, slot1, slot0}.
            case (pm)
                PERM_LAST: q = {d_a[2*k+1], s_a[2*k+1], d_a[2*k], s_a[2*k]};
                PERM_SWAP: q = {d_a[2*k], d_a[2*k+1], s_a[2*k], s_a[2*k+1]};
                default:   q = {d_a[2*k+1], d_a[2*k], s_a[2*k+1], s_a[2*k]};
            endcase
        end
        assign y_perm[4*k*D_BIT +: 4*D_BIT] = q;
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            oVALID <= 1'b0;
            oOVF   <= 1'b0;
            oY     <= '0;
        end else begin
            v1     <= en1;
            v2     <= en2;
            oVALID <= en3;
            if (en3)
                oY <= y_perm;
            if (iCLR)
                oOVF <= 1'b0;
            else if (v2 && (|ovf_v))
                oOVF <= 1'b1;
        end
    end

endmodule
